// File: rtl/display_pkg.sv
// Shared display definitions for the sequencer responders (clear, foreground, wait):
// default geometry, colour type, responder state encoding and the checkerboard helper.
package display_pkg;

  localparam int COLOR_CHANNEL_DEPTH = 2;
  localparam int SCREEN_W            = 160;
  localparam int SCREEN_H            = 120;
  localparam int COLOR_W             = 3 * COLOR_CHANNEL_DEPTH;

  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } resp_state_e;

  // Checkerboard cell parity on 8x8 tiles.
  function automatic logic checker_odd(input logic [7:0] x, input logic [6:0] y);
    return x[3] ^ y[3];
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Row-major pixel raster counter: x steps across a row, wraps and bumps y.
// Also exposes next-state coordinates so callers can register per-pixel data in step.
module raster_counter #(
  parameter int W = display_pkg::SCREEN_W,
  parameter int H = display_pkg::SCREEN_H
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic [7:0] x_nxt_o,
  output logic [6:0] y_nxt_o,
  output logic       last_pixel_o
);

  localparam logic [7:0] X_LAST = 8'(W - 1);
  localparam logic [6:0] Y_LAST = 7'(H - 1);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 7'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign x_nxt_o      = x_d;
  assign y_nxt_o      = y_d;
  assign last_pixel_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/screen_clear.sv
// Clear responder: on enable, writes every frame-buffer pixel once, then handshakes done.
// Build option SCREEN_CLEAR_PATTERN_EN swaps the flat background for a checkerboard.
module screen_clear #(
  parameter int COLOR_CHANNEL_DEPTH                    = display_pkg::COLOR_CHANNEL_DEPTH,
  parameter int SCREEN_W                               = display_pkg::SCREEN_W,
  parameter int SCREEN_H                               = display_pkg::SCREEN_H,
  parameter logic [3*COLOR_CHANNEL_DEPTH-1:0] BG_COLOR = '0
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             enable,
  output logic [7:0]                       x,
  output logic [6:0]                       y,
  output logic [3*COLOR_CHANNEL_DEPTH-1:0] color,
  output logic                             writeEn,
  output logic                             done
);
  import display_pkg::*;

  localparam int CW = 3 * COLOR_CHANNEL_DEPTH;
`ifdef SCREEN_CLEAR_PATTERN_EN
  localparam logic PATTERN_EN = 1'b1;
`else
  localparam logic PATTERN_EN = 1'b0;
`endif

  resp_state_e state_q;
  logic        wr_en_q, done_q;
  logic [CW-1:0] color_q, color_d;

  logic       advance, clear, last_pixel;
  logic [7:0] x_nxt;
  logic [6:0] y_nxt;

  // The counter only moves while a sweep continues; any other path parks it at (0,0),
  // which covers abort, completion and illegal-state recovery in one place.
  assign advance = (state_q == SWEEP) && enable && !last_pixel;
  assign clear   = !advance;

  raster_counter #(
    .W (SCREEN_W),
    .H (SCREEN_H)
  ) u_raster (
    .clock        (clock),
    .resetn       (resetn),
    .clear_i      (clear),
    .advance_i    (advance),
    .x_o          (x),
    .y_o          (y),
    .x_nxt_o      (x_nxt),
    .y_nxt_o      (y_nxt),
    .last_pixel_o (last_pixel)
  );

  // Colour follows the next coordinates so it lands in the same cycle as x/y.
  assign color_d = (PATTERN_EN && checker_odd(x_nxt, y_nxt)) ? ~BG_COLOR : BG_COLOR;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      color_q <= BG_COLOR;
    end else begin
      color_q <= color_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (enable) begin
            state_q <= SWEEP;
            wr_en_q <= 1'b1;
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        SWEEP: begin
          if (!enable) begin
            state_q <= IDLE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
          end else if (last_pixel) begin
            state_q <= DONE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          wr_en_q <= 1'b0;
          if (!enable) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          color_q <= BG_COLOR;
        end
      endcase
    end
  end

  assign writeEn = wr_en_q;
  assign done    = done_q;
  assign color   = color_q;

endmodule

// File: tb/tb_screen_clear.sv
// Bench for screen_clear: a 4x3 instance for handshake/abort/reset and a 16x16 instance
// for the colour pattern; expected writes come from a row-major pixel list model.
module tb_screen_clear;

  localparam int          W    = 4;
  localparam int          H    = 3;
  localparam int          W2   = 16;
  localparam int          H2   = 16;
  localparam logic [5:0]  BG   = 6'h15;

  typedef struct {
    int         px;
    int         py;
    logic [5:0] c;
  } pix_t;

  logic       clock, resetn, enable, en2;
  logic [7:0] x, x2;
  logic [6:0] y, y2;
  logic [5:0] color, color2;
  logic       writeEn, done, writeEn2, done2;

  int tests = 0;
  int fails = 0;

  screen_clear #(
    .COLOR_CHANNEL_DEPTH (2),
    .SCREEN_W            (W),
    .SCREEN_H            (H),
    .BG_COLOR            (BG)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (enable),
    .x       (x),
    .y       (y),
    .color   (color),
    .writeEn (writeEn),
    .done    (done)
  );

  screen_clear #(
    .COLOR_CHANNEL_DEPTH (2),
    .SCREEN_W            (W2),
    .SCREEN_H            (H2),
    .BG_COLOR            (BG)
  ) dut16 (
    .clock   (clock),
    .resetn  (resetn),
    .enable  (en2),
    .x       (x2),
    .y       (y2),
    .color   (color2),
    .writeEn (writeEn2),
    .done    (done2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference colour: flat background, or 8x8 checkerboard when the pattern build is on.
  function automatic logic [5:0] exp_color(input int px, input int py);
`ifdef SCREEN_CLEAR_PATTERN_EN
    if ((((px / 8) % 2) + ((py / 8) % 2)) % 2 == 1) return ~BG;
`endif
    return BG;
  endfunction

  function automatic void build_frame(input int fw, input int fh, output pix_t q[$]);
    q = {};
    for (int r = 0; r < fh; r++)
      for (int c = 0; c < fw; c++)
        q.push_back('{px: c, py: r, c: exp_color(c, r)});
  endfunction

  task automatic test_reset;
    resetn = 1'b0;
    enable = 1'b0;
    en2    = 1'b0;
    repeat (2) tick;
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      tests++;
      if (writeEn !== 1'b0 || done !== 1'b0 || x !== 8'd0 || y !== 7'd0 || color !== BG) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got we=%b done=%b x=%0d y=%0d c=%h want 0 0 0 0 %h",
                 i, writeEn, done, x, y, color, BG);
      end
    end
  endtask

  // Full sweep from IDLE, hold done, then release and check done drops.
  task automatic test_full_sweep(input string tag, input int hold);
    pix_t q[$];
    int   n = 0;
    bit   seen_done = 0;
    bit   gap = 0;
    build_frame(W, H, q);
    enable = 1'b1;
    for (int cyc = 0; cyc < 60 && !seen_done; cyc++) begin
      tick;
      if (done === 1'b1) begin
        seen_done = 1;
        tests++;
        if (writeEn !== 1'b0) begin
          fails++;
          $display("FAIL %s done_with_write got we=%b want 0", tag, writeEn);
        end
      end else if (writeEn === 1'b1) begin
        tests++;
        if (n >= q.size()) begin
          fails++;
          $display("FAIL %s extra_write got (%0d,%0d) want none", tag, x, y);
        end else if (x !== 8'(q[n].px) || y !== 7'(q[n].py) || color !== q[n].c) begin
          fails++;
          $display("FAIL %s pixel%0d got (%0d,%0d,%h) want (%0d,%0d,%h)",
                   tag, n, x, y, color, q[n].px, q[n].py, q[n].c);
        end
        n++;
      end else begin
        gap = 1;
      end
    end
    tests++;
    if (!seen_done || n != W * H || gap) begin
      fails++;
      $display("FAIL %s sweep_summary got done=%0d writes=%0d gap=%0d want 1 %0d 0",
               tag, seen_done, n, gap, W * H);
    end
    for (int i = 0; i < hold; i++) begin
      tick;
      tests++;
      if (done !== 1'b1 || writeEn !== 1'b0) begin
        fails++;
        $display("FAIL %s done_hold cyc=%0d got done=%b we=%b want 1 0", tag, i, done, writeEn);
      end
    end
    enable = 1'b0;
    tick;
    tests++;
    if (done !== 1'b0 || writeEn !== 1'b0 || x !== 8'd0 || y !== 7'd0) begin
      fails++;
      $display("FAIL %s done_release got done=%b we=%b x=%0d y=%0d want 0 0 0 0",
               tag, done, writeEn, x, y);
    end
  endtask

  // Drop enable once the nth write is visible; sweep must stop with no done.
  task automatic test_abort(input int nabort);
    int  n = 0;
    bit  got_done = 0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 40 && n < nabort; cyc++) begin
      tick;
      if (writeEn === 1'b1) n++;
      if (done === 1'b1) got_done = 1;
    end
    tests++;
    if (n != nabort) begin
      fails++;
      $display("FAIL abort_reach got writes=%0d want %0d", n, nabort);
    end
    enable = 1'b0;
    tick;
    tests++;
    if (writeEn !== 1'b0 || done !== 1'b0 || x !== 8'd0 || y !== 7'd0) begin
      fails++;
      $display("FAIL abort_stop n=%0d got we=%b done=%b x=%0d y=%0d want 0 0 0 0",
               nabort, writeEn, done, x, y);
    end
    repeat (4) begin
      tick;
      if (done === 1'b1 || writeEn === 1'b1) got_done = 1;
    end
    tests++;
    if (got_done) begin
      fails++;
      $display("FAIL abort_quiet n=%0d got activity after abort want none", nabort);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n = 0;
    enable = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 7; cyc++) begin
      tick;
      if (writeEn === 1'b1) n++;
    end
    tests++;
    if (n != 7) begin
      fails++;
      $display("FAIL rst_mid_reach got writes=%0d want 7", n);
    end
    resetn = 1'b0;
    #1;
    tests++;
    if (writeEn !== 1'b0 || done !== 1'b0 || x !== 8'd0 || y !== 7'd0 || color !== BG) begin
      fails++;
      $display("FAIL rst_async got we=%b done=%b x=%0d y=%0d c=%h want 0 0 0 0 %h",
               writeEn, done, x, y, color, BG);
    end
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    test_full_sweep("after_reset", 2);
  endtask

  task automatic test_pattern;
    pix_t q[$];
    int   n = 0;
    bit   seen_done = 0;
    bit   bad = 0;
    build_frame(W2, H2, q);
    en2 = 1'b1;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      tick;
      if (done2 === 1'b1) seen_done = 1;
      else if (writeEn2 === 1'b1) begin
        if (n >= q.size() || x2 !== 8'(q[n].px) || y2 !== 7'(q[n].py) || color2 !== q[n].c) begin
          if (!bad && n < q.size())
            $display("FAIL pattern pixel%0d got (%0d,%0d,%h) want (%0d,%0d,%h)",
                     n, x2, y2, color2, q[n].px, q[n].py, q[n].c);
          bad = 1;
        end
        n++;
      end
    end
    tests++;
    if (bad) fails++;
    tests++;
    if (!seen_done || n != W2 * H2) begin
      fails++;
      $display("FAIL pattern_count got done=%0d writes=%0d want 1 %0d", seen_done, n, W2 * H2);
    end
    en2 = 1'b0;
    tick;
    tests++;
    if (done2 !== 1'b0) begin
      fails++;
      $display("FAIL pattern_release got done=%b want 0", done2);
    end
  endtask

  initial begin
    test_reset;
    test_full_sweep("sweep1", 5);
    tick;
    test_full_sweep("sweep2", 5);
    test_abort(5);
    test_full_sweep("restart", 1);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      test_abort($urandom_range(1, W * H));
    end
    test_abort(W * H);
    test_full_sweep("after_last_abort", $urandom_range(0, 4));
    repeat ($urandom_range(1, 3)) tick;
    test_reset_mid_sweep;
    test_pattern;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
